// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset PC default, NOP word and the alignment helper.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // A target is word-aligned only when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack and the IF->ID handoff.
interface pc_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    output imem_ack, imem_rdata, id_ready
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// Redirect priority mux (jr > jump > branch) with word alignment of the
// selected target and a flag for a misaligned request.
module pc_redirect_sel
  import pc_fetch_pkg::*;
(
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        redir_valid,
  output logic [31:0] redir_target,
  output logic        redir_misalign
);

  logic [31:0] raw_target_s;

  // Pick the highest-priority active redirect source.
  always_comb begin
    redir_valid  = 1'b0;
    raw_target_s = 32'h0000_0000;
    if (jr_en) begin
      redir_valid  = 1'b1;
      raw_target_s = jr_addr;
    end else if (jump_en) begin
      redir_valid  = 1'b1;
      raw_target_s = jump_target;
    end else if (branch_en) begin
      redir_valid  = 1'b1;
      raw_target_s = branch_target;
    end else begin
      redir_valid  = 1'b0;
      raw_target_s = 32'h0000_0000;
    end
  end

  assign redir_target   = {raw_target_s[31:2], 2'b00};
  assign redir_misalign = redir_valid & is_misaligned(raw_target_s[1:0]);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry output
// buffer toward decode, and redirect handling that never lets a fetch
// issued on a stale path reach if_instr.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_fetch_if.master  bus,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        addr_err
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  pend_pc_r;
  logic         imem_req_r;
  logic         if_valid_r;
  logic [31:0]  if_instr_r;
  logic [31:0]  if_pc_r;
  logic [31:0]  if_pc4_r;
  logic         addr_err_r;

  logic         redir_s;
  logic [31:0]  redir_tgt_s;
  logic         misalign_s;
  logic [31:0]  pc4_s;

  pc_redirect_sel u_redirect_sel (
    .jr_en          (jr_en),
    .jr_addr        (jr_addr),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .branch_en      (branch_en),
    .branch_target  (branch_target),
    .redir_valid    (redir_s),
    .redir_target   (redir_tgt_s),
    .redir_misalign (misalign_s)
  );

  // Wraps naturally at 2^32.
  assign pc4_s = pc_r + 32'd4;

  // Fetch FSM: all state and outputs registered. The imem address is
  // always pc_r; in DRAIN pc_r is left alone so the address stays stable
  // while the redirect target waits in pend_pc_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_REQ;
      pc_r       <= RESET_PC;
      pend_pc_r  <= RESET_PC;
      imem_req_r <= 1'b1;
      if_valid_r <= 1'b0;
      if_instr_r <= NOP;
      if_pc_r    <= 32'h0000_0000;
      if_pc4_r   <= 32'h0000_0000;
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= redir_s & misalign_s;
      case (state_r)
        ST_REQ: begin
          if (redir_s) begin
            if (bus.imem_ack) begin
              pc_r <= redir_tgt_s;
            end else begin
              pend_pc_r <= redir_tgt_s;
              state_r   <= ST_DRAIN;
            end
          end else if (bus.imem_ack) begin
            if_instr_r <= bus.imem_rdata;
            if_pc_r    <= pc_r;
            if_pc4_r   <= pc4_s;
            pc_r       <= pc4_s;
            if_valid_r <= 1'b1;
            imem_req_r <= 1'b0;
            state_r    <= ST_FULL;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_ack) begin
            pc_r    <= redir_s ? redir_tgt_s : pend_pc_r;
            state_r <= ST_REQ;
          end else if (redir_s) begin
            pend_pc_r <= redir_tgt_s;
          end
        end
        ST_FULL: begin
          if (redir_s) begin
            pc_r       <= redir_tgt_s;
            if_valid_r <= 1'b0;
            imem_req_r <= 1'b1;
            state_r    <= ST_REQ;
          end else if (bus.id_ready) begin
            if_valid_r <= 1'b0;
            imem_req_r <= 1'b1;
            state_r    <= ST_REQ;
          end
        end
        default: begin
          if_valid_r <= 1'b0;
          imem_req_r <= 1'b1;
          state_r    <= ST_REQ;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = pc_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.if_instr  = if_instr_r;
  assign bus.if_pc     = if_pc_r;
  assign bus.if_pc4    = if_pc4_r;
  assign addr_err      = addr_err_r;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory request; held high until imem_ack.
REQ-005 imem_addr  output  32  fetch address; stable while imem_req is high.
REQ-006 imem_ack  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 if_valid  output  1  if_instr and if_pc hold a valid fetched instruction.
REQ-009 id_ready  input  1  decode consumes the instruction when if_valid and id_ready are both 1.
REQ-010 if_instr, if_pc, if_pc4  output  32 each  instruction, its address, its address+4.
REQ-011 jr_en/jr_addr, jump_en/jump_target, branch_en/branch_target  input  1/32 each  redirect requests from downstream; jump_target is the {pc4[31:28], instr[25:0], 2'b00} value.
REQ-012 addr_err  output  1  one-cycle pulse when an accepted redirect target has bits [1:0] != 0.

Function
REQ-013 The FSM SHALL have three states: REQ (fetch in flight), DRAIN (discard an in-flight fetch), and FULL (instruction held for decode).
REQ-014 In REQ: imem_req=1 and imem_addr=pc; on imem_ack with no redirect, capture imem_rdata, pc, and pc+4 into if_instr/if_pc/if_pc4, set pc<=pc+4, and go to FULL.
REQ-015 In FULL: imem_req=0 and if_valid=1; on id_ready with no redirect, clear if_valid and go to REQ; without id_ready, hold all outputs.
REQ-016 Redirect priority SHALL be jr_en > jump_en > branch_en; the selected target has bits [1:0] forced to 0.
REQ-017 Redirect in FULL: clear if_valid (flush), load pc with the target, and go to REQ.
REQ-018 Redirect in REQ with imem_ack in the same cycle: discard imem_rdata, load pc with the target, and stay in REQ.
REQ-019 Redirect in REQ without imem_ack: keep imem_addr unchanged, latch the target in pend_pc, and go to DRAIN.
REQ-020 In DRAIN: imem_req=1 at the old address; any redirect overwrites pend_pc (latest wins); on imem_ack, discard the data, set pc<=pend_pc, and go to REQ.
REQ-021 if_valid SHALL be 0 in REQ and DRAIN; no discarded instruction ever reaches if_instr.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no error.
REQ-023 Minimum throughput is one instruction per two cycles (REQ->FULL->REQ) with imem_ack tied high and id_ready tied high.

Reset
REQ-024 While rst_n=0, regardless of clk: state=REQ, pc=RESET_PC, pend_pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, addr_err=0.
REQ-025 imem_req SHALL assert in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-026 Reset asserted mid-fetch (REQ or DRAIN) SHALL abandon the fetch with no pending state retained.

Structure
REQ-027 A shared package SHALL hold the state encoding (REQ=2'd0, DRAIN=2'd1, FULL=2'd2), RESET_PC, and the NOP constant 32'h0000_0000.
REQ-028 One sub-module, pc_redirect_sel (combinational priority mux plus alignment check), SHALL produce the redirect target, a redirect flag, and the misalign flag.

Verification
REQ-029 Reset release, imem_ack=1, id_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008 on alternating cycles; if_pc matches.
REQ-030 In FULL with id_ready=0 for 5 cycles -> if_instr/if_pc stable and imem_req=0; id_ready=1 -> next fetch at if_pc+4.
REQ-031 jump_en=1, jump_target=0x00400100, in REQ with imem_ack=0 -> DRAIN, imem_addr unchanged; on ack, data dropped and next imem_addr=0x00400100.
REQ-032 jr_en and branch_en asserted together in FULL (jr_addr=0x00401002, branch_target=0x00400200) -> if_valid drops, next imem_addr=0x00401000, addr_err pulses once.
REQ-033 pc=0xFFFFFFFC fetched -> if_pc4=0x00000000 and next imem_addr=0x00000000.
REQ-034 rst_n pulsed low mid-DRAIN -> all outputs reset asynchronously; first request after release at 0x00400000.
